// File: rtl/seg_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : seg_sched_pkg                                          |
// | Shared types, constants and small helpers for the seven-segment  |
// | display scheduler (state enum, client count, dash symbol).       |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package seg_sched_pkg;

  localparam int N_CLIENTS = 3;
  localparam logic [3:0] SYM_DASH = 4'h9;
  localparam logic [15:0] DEFAULT_IDLE_PATTERN = {4{SYM_DASH}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } sched_state_t;

  // Next index in round-robin order (mod 3).
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Request bit of a client; an out-of-range index reads as no request.
  function automatic logic req_bit(input logic [N_CLIENTS-1:0] req, input logic [1:0] idx);
    case (idx)
      2'd0:    return req[0];
      2'd1:    return req[1];
      2'd2:    return req[2];
      default: return 1'b0;
    endcase
  endfunction

  // Three-way word select by client index.
  function automatic logic [15:0] mux3(input logic [1:0] idx, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] c);
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  // One-hot grant for a client index.
  function automatic logic [N_CLIENTS-1:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : seg_display_scheduler_if                             |
// | Client request/data bundle and display-side outputs.             |
// |   req[2:0]      per-client level request                         |
// |   nums0..nums2  client display words                             |
// |   nums_out      word to SevenSegment.nums                        |
// |   grant[2:0]    one-hot owner, zero when idle                    |
// |   busy          high whenever grant is non-zero                  |
// | Modports: master (clients side), slave (scheduler side).         |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface seg_display_scheduler_if import seg_sched_pkg::*; ();

  logic [N_CLIENTS-1:0] req;
  logic [15:0]          nums0;
  logic [15:0]          nums1;
  logic [15:0]          nums2;
  logic [15:0]          nums_out;
  logic [N_CLIENTS-1:0] grant;
  logic                 busy;

  modport master (
    output req, nums0, nums1, nums2,
    input  nums_out, grant, busy
  );

  modport slave (
    input  req, nums0, nums1, nums2,
    output nums_out, grant, busy
  );

endinterface
`default_nettype wire

// File: rtl/seg_display_scheduler_rr_pick3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rr_pick3                                                |
// | Combinational 3-way round-robin picker. Search order is          |
// | last+1, last+2, last (mod 3); one index may be excluded.         |
// |   req[2:0], last[1:0], exclude_en, exclude_idx[1:0] -> valid,idx |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module rr_pick3
  import seg_sched_pkg::*;
(
  input  logic [N_CLIENTS-1:0] req,
  input  logic [1:0]           last,
  input  logic                 exclude_en,
  input  logic [1:0]           exclude_idx,
  output logic                 valid,
  output logic [1:0]           idx
);

  logic [1:0] w_c0, w_c1, w_c2;
  logic       w_ok0, w_ok1, w_ok2;

  assign w_c0 = rr_next(last);
  assign w_c1 = rr_next(w_c0);
  assign w_c2 = rr_next(w_c1);

  assign w_ok0 = req_bit(req, w_c0) & ~(exclude_en & (exclude_idx == w_c0));
  assign w_ok1 = req_bit(req, w_c1) & ~(exclude_en & (exclude_idx == w_c1));
  assign w_ok2 = req_bit(req, w_c2) & ~(exclude_en & (exclude_idx == w_c2));

  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    if (w_ok0) begin
      valid = 1'b1;
      idx   = w_c0;
    end else if (w_ok1) begin
      valid = 1'b1;
      idx   = w_c1;
    end else if (w_ok2) begin
      valid = 1'b1;
      idx   = w_c2;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : seg_display_scheduler                                   |
// | Time-shares one four-digit seven-segment display among three     |
// | clients: round-robin arbitration, minimum hold time per grant,   |
// | dash pattern when idle.                                          |
// |   clk, rst (sync, active-high)                                   |
// |   bus : seg_display_scheduler_if.slave (req, nums0..2 in;        |
// |         nums_out, grant, busy out - all registered)              |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter logic [23:0] HOLD_CYCLES  = 24'd1_000_000,
  parameter logic [15:0] IDLE_PATTERN = DEFAULT_IDLE_PATTERN
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_display_scheduler_if.slave bus
);

  localparam logic [23:0] c_RELOAD = HOLD_CYCLES - 24'd1;

  sched_state_t         r_state, w_state_nxt;
  logic [23:0]          r_cnt, w_cnt_nxt;
  logic [1:0]           r_last, w_last_nxt;   // also the current owner while busy
  logic [N_CLIENTS-1:0] r_grant, w_grant_nxt;
  logic [15:0]          r_nums, w_nums_nxt;
  logic                 r_busy;

  logic        w_pick_valid;
  logic [1:0]  w_pick_idx;
  logic        w_owner_req;
  logic [15:0] w_owner_nums;
  logic [15:0] w_pick_nums;

  // In OPEN only non-owners may take over; elsewhere the owner is simply
  // searched last, which the round-robin order already provides.
  rr_pick3 u_pick (
    .req         (bus.req),
    .last        (r_last),
    .exclude_en  (r_state == ST_OPEN),
    .exclude_idx (r_last),
    .valid       (w_pick_valid),
    .idx         (w_pick_idx)
  );

  assign w_owner_req  = req_bit(bus.req, r_last);
  assign w_owner_nums = mux3(r_last, bus.nums0, bus.nums1, bus.nums2);
  assign w_pick_nums  = mux3(w_pick_idx, bus.nums0, bus.nums1, bus.nums2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_nums_nxt  = r_nums;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_nums_nxt  = IDLE_PATTERN;
        if (w_pick_valid) begin
          w_state_nxt = ST_HOLD;
          w_last_nxt  = w_pick_idx;
          w_grant_nxt = onehot3(w_pick_idx);
          w_cnt_nxt   = c_RELOAD;
          w_nums_nxt  = w_pick_nums;
        end
      end
      ST_HOLD: begin
        if (r_cnt != 24'd0) begin
          w_cnt_nxt = r_cnt - 24'd1;
          // Owner dropping req mid-hold freezes the word so short notes stay visible.
          if (w_owner_req) w_nums_nxt = w_owner_nums;
        end else if (w_pick_valid && (w_pick_idx != r_last)) begin
          w_last_nxt  = w_pick_idx;
          w_grant_nxt = onehot3(w_pick_idx);
          w_cnt_nxt   = c_RELOAD;
          w_nums_nxt  = w_pick_nums;
        end else if (w_pick_valid) begin
          w_state_nxt = ST_OPEN;
          w_nums_nxt  = w_owner_nums;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_nums_nxt  = IDLE_PATTERN;
        end
      end
      ST_OPEN: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_HOLD;
          w_last_nxt  = w_pick_idx;
          w_grant_nxt = onehot3(w_pick_idx);
          w_cnt_nxt   = c_RELOAD;
          w_nums_nxt  = w_pick_nums;
        end else if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_nums_nxt  = IDLE_PATTERN;
        end else begin
          w_nums_nxt = w_owner_nums;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_nums_nxt  = IDLE_PATTERN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 24'd0;
      r_last  <= 2'd2;       // client 0 is first in line after reset
      r_grant <= '0;
      r_nums  <= IDLE_PATTERN;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_nums  <= w_nums_nxt;
      r_busy  <= |w_grant_nxt;
    end
  end

  assign bus.nums_out = r_nums;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_seg_display_scheduler                                |
// | Directed self-checking bench for seg_display_scheduler with      |
// | HOLD_CYCLES=4.                                                   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_seg_display_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seg_display_scheduler_if bus ();

  seg_display_scheduler #(
    .HOLD_CYCLES  (24'd4),
    .IDLE_PATTERN (16'h9999)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Advance one rising edge; outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic [15:0] n);
    check_eq({tag, "_grant"}, {29'd0, bus.grant}, {29'd0, g});
    check_eq({tag, "_nums"},  {16'd0, bus.nums_out}, {16'd0, n});
    check_eq({tag, "_busy"},  {31'd0, bus.busy}, {31'd0, (g != 3'b000)});
  endtask

  initial begin
    logic [2:0]  exp_g;
    logic [15:0] exp_n;
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    bus.req   = 3'b000;
    bus.nums0 = 16'h1111;
    bus.nums1 = 16'h0123;
    bus.nums2 = 16'h3333;

    // Reset then idle
    step();
    step();
    expect_out("reset", 3'b000, 16'h9999);
    rst = 1'b0;
    step();
    expect_out("idle", 3'b000, 16'h9999);

    // Single short request from client 1: held 4 cycles, data frozen
    bus.req = 3'b010;
    step();
    bus.req   = 3'b000;
    bus.nums1 = 16'h0456;
    expect_out("short_h0", 3'b010, 16'h0123);
    for (int k = 1; k < 4; k++) begin
      step();
      expect_out($sformatf("short_h%0d", k), 3'b010, 16'h0123);
    end
    step();
    expect_out("short_rel", 3'b000, 16'h9999);

    // Simultaneous first request after reset: client 0 wins
    rst = 1'b1;
    step();
    rst       = 1'b0;
    bus.nums1 = 16'h2222;
    bus.req   = 3'b111;
    step();
    expect_out("simul_first", 3'b001, 16'h1111);

    // Continuous contention: 001 -> 010 -> 100 -> 001, 4 cycles each
    for (int n = 1; n <= 12; n++) begin
      step();
      case ((n / 4) % 3)
        0:       begin exp_g = 3'b001; exp_n = 16'h1111; end
        1:       begin exp_g = 3'b010; exp_n = 16'h2222; end
        default: begin exp_g = 3'b100; exp_n = 16'h3333; end
      endcase
      expect_out($sformatf("rr_n%0d", n), exp_g, exp_n);
    end

    // OPEN preemption: client 2 alone for 10 cycles, then client 0 arrives
    rst = 1'b1;
    step();
    rst     = 1'b0;
    bus.req = 3'b100;
    step();
    expect_out("open_g0", 3'b100, 16'h3333);
    for (int k = 1; k < 10; k++) begin
      if (k == 6) bus.nums2 = 16'h0abc;
      step();
      expect_out($sformatf("open_k%0d", k), 3'b100, (k >= 6) ? 16'h0abc : 16'h3333);
    end
    bus.req = 3'b101;
    step();
    expect_out("preempt", 3'b001, 16'h1111);
    for (int k = 1; k < 4; k++) begin
      step();
      expect_out($sformatf("preempt_h%0d", k), 3'b001, 16'h1111);
    end
    step();
    expect_out("preempt_back", 3'b100, 16'h0abc);

    // Reset mid-HOLD, then a pending client 2 request is granted promptly
    step();
    rst     = 1'b1;
    bus.req = 3'b100;
    step();
    expect_out("rst_mid", 3'b000, 16'h9999);
    rst = 1'b0;
    step();
    expect_out("post_rst", 3'b100, 16'h0abc);

    // Enter OPEN then release when the owner drops its request
    for (int k = 1; k < 6; k++) step();
    expect_out("open_stay", 3'b100, 16'h0abc);
    bus.req = 3'b000;
    step();
    expect_out("open_rel", 3'b000, 16'h9999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
